// File: rtl/rrab_pkg.sv
// Shared definitions for the 2-way round-robin arbiter and its requester agents.
package rrab_pkg;

  localparam int unsigned RRAB_NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } rrab_state_e;

endpackage

// File: rtl/rrab_client_fifo.sv
// Job-length FIFO: registered pointers, head visible combinationally one cycle after push.
// Pushes are ignored when full and pops when empty; no push-through on a full FIFO.
module rrab_client_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/rrab_client.sv
// Requester agent: queues bursts, requests the arbiter, streams beats while granted (grant->beat 1 cycle).
// job_ready is !full; beats pause while grant is low; request drops one cycle after each burst.
module rrab_client
  import rrab_pkg::*;
#(
  parameter int LEN_W      = 4,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             request,
  input  logic             grant,
  output logic             beat_valid,
  output logic             beat_last,
  output logic [LEN_W-1:0] beat_idx,
  output logic             busy,
  output logic             starve
);

  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  rrab_state_e      state_q, state_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             starve_q, starve_d;
  logic [7:0]       wait_q, wait_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] fifo_dout;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

  // Zero-length jobs are acknowledged but never stored.
  assign job_ready  = !fifo_full;
  assign fifo_push  = job_valid && job_ready && (job_len != '0);
  assign last_idx   = cur_len_q - 1'b1;
  assign beat_valid = (state_q == XFER) && grant;
  assign beat_last  = beat_valid && (idx_q == last_idx);
  assign beat_idx   = idx_q;
  assign request    = req_q;
  assign busy       = busy_q;
  assign starve     = starve_q;

  rrab_client_fifo #(
    .W     (LEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .din_i   (job_len),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    idx_d     = idx_q;
    cur_len_d = cur_len_q;
    wait_d    = wait_q;
    starve_d  = starve_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = REQ;
          req_d   = 1'b1;
          wait_d  = '0;
        end
      end
      REQ: begin
        if (grant) begin
          fifo_pop  = 1'b1;
          cur_len_d = fifo_dout;
          idx_d     = '0;
          state_d   = XFER;
        end else begin
          if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
          if (wait_d >= LIM) starve_d = 1'b1;
        end
      end
      XFER: begin
        if (grant) begin
          if (idx_q == last_idx) begin
            state_d = REL;
            req_d   = 1'b0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      REL: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      starve_q  <= 1'b0;
      wait_q    <= '0;
      idx_q     <= '0;
      cur_len_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      starve_q  <= starve_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      cur_len_q <= cur_len_d;
    end
  end

endmodule

// File: tb/tb_rrab_client.sv
// Directed bench for rrab_client with hand-computed cycle-by-cycle expectations.
module tb_rrab_client;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       job_valid = 1'b0;
  logic [3:0] job_len = 4'd0;
  logic       job_ready;
  logic       request;
  logic       grant = 1'b0;
  logic       beat_valid;
  logic       beat_last;
  logic [3:0] beat_idx;
  logic       busy;
  logic       starve;

  int n_chk  = 0;
  int n_pass = 0;

  rrab_client #(
    .LEN_W      (4),
    .DEPTH      (4),
    .STARVE_LIM (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .job_valid  (job_valid),
    .job_len    (job_len),
    .job_ready  (job_ready),
    .request    (request),
    .grant      (grant),
    .beat_valid (beat_valid),
    .beat_last  (beat_last),
    .beat_idx   (beat_idx),
    .busy       (busy),
    .starve     (starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance past the next rising edge; a pushed job is offered for exactly one edge.
  task automatic tick();
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] len);
    job_valid = 1'b1;
    job_len   = len;
  endtask

  task automatic cyc(input string tag, input logic g, input logic r, input logic bv,
                     input logic [3:0] idx, input logic last);
    tick();
    grant = g;
    #1;
    chk({tag, ".req"},  32'(request),    32'(r));
    chk({tag, ".bv"},   32'(beat_valid), 32'(bv));
    chk({tag, ".idx"},  32'(beat_idx),   32'(idx));
    chk({tag, ".last"}, 32'(beat_last),  32'(last));
  endtask

  task automatic do_reset();
    grant = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
  endtask

  int beats;
  int lasts;
  int reqs;

  initial begin
    // Reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle.req",   32'(request),    32'd0);
      chk("idle.ready", 32'(job_ready),  32'd1);
      chk("idle.bv",    32'(beat_valid), 32'd0);
    end
    chk("idle.busy",   32'(busy),   32'd0);
    chk("idle.starve", 32'(starve), 32'd0);

    // Single burst of 3 with grant tied high
    do_reset();
    grant = 1'b1;
    push(4'd3);
    cyc("sb0", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc("sb1", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc("sb2", 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
    cyc("sb3", 1'b1, 1'b1, 1'b1, 4'd1, 1'b0);
    cyc("sb4", 1'b1, 1'b1, 1'b1, 4'd2, 1'b1);
    cyc("sb5", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("sb5.busy", 32'(busy), 32'd1);
    cyc("sb6", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("sb6.busy", 32'(busy), 32'd0);

    // Grant stall mid-burst of 4
    do_reset();
    push(4'd4);
    cyc("gs0", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc("gs1", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc("gs2", 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
    cyc("gs3", 1'b1, 1'b1, 1'b1, 4'd1, 1'b0);
    cyc("gs4", 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    cyc("gs5", 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    cyc("gs6", 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    cyc("gs7", 1'b1, 1'b1, 1'b1, 4'd2, 1'b0);
    cyc("gs8", 1'b1, 1'b1, 1'b1, 4'd3, 1'b1);
    cyc("gs9", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc("gsA", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

    // Zero-length drop, then fill the FIFO with grant low
    do_reset();
    push(4'd0);
    tick();
    chk("len0.ready", 32'(job_ready), 32'd1);
    tick();
    tick();
    chk("len0.req",  32'(request), 32'd0);
    chk("len0.busy", 32'(busy),    32'd0);
    push(4'd5);
    tick();
    push(4'd5);
    tick();
    push(4'd5);
    tick();
    chk("fill3.ready", 32'(job_ready), 32'd1);
    push(4'd5);
    tick();
    chk("full.ready", 32'(job_ready), 32'd0);
    chk("full.req",   32'(request),   32'd1);
    grant = 1'b1;
    #1;
    chk("nopt.ready", 32'(job_ready), 32'd0);
    tick();
    chk("popped.ready", 32'(job_ready), 32'd1);
    beats = 0;
    lasts = 0;
    for (int i = 0; i < 60; i++) begin
      if (beat_valid) beats++;
      if (beat_last) lasts++;
      tick();
    end
    chk("drain.beats", 32'(beats), 32'd20);
    chk("drain.lasts", 32'(lasts), 32'd4);

    // Starvation after 16 ungranted cycles in REQ
    do_reset();
    push(4'd1);
    tick();
    tick();
    chk("stv.req", 32'(request), 32'd1);
    repeat (15) tick();
    chk("stv.pre", 32'(starve), 32'd0);
    tick();
    chk("stv.set", 32'(starve), 32'd1);
    grant = 1'b1;
    tick();
    #1;
    chk("stv.bv",   32'(beat_valid), 32'd1);
    chk("stv.last", 32'(beat_last),  32'd1);
    tick();
    tick();
    chk("stv.busy", 32'(busy),   32'd0);
    chk("stv.held", 32'(starve), 32'd1);

    // Asynchronous reset during beat 1 of a 6-beat burst, with a second job queued
    do_reset();
    grant = 1'b1;
    push(4'd6);
    tick();
    push(4'd2);
    tick();
    tick();
    tick();
    chk("ar.idx", 32'(beat_idx),   32'd1);
    chk("ar.bv",  32'(beat_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("ar.bv0",    32'(beat_valid), 32'd0);
    chk("ar.req0",   32'(request),    32'd0);
    chk("ar.busy0",  32'(busy),       32'd0);
    chk("ar.ready1", 32'(job_ready),  32'd1);
    chk("ar.idx0",   32'(beat_idx),   32'd0);
    tick();
    tick();
    reset = 1'b0;
    beats = 0;
    reqs  = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (beat_valid) beats++;
      if (request) reqs++;
    end
    chk("ar.beats", 32'(beats), 32'd0);
    chk("ar.reqs",  32'(reqs),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
